// File: rtl/sprite_scheduler_if.sv
// Bus between the sprite scheduler, the renderer bank and the shared bitmap ROM.
// The master side is the scheduler; the slave side is the renderer bank plus the ROM.
interface sprite_scheduler_if #(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
);
  logic [NUM_SPRITES-1:0]        in_progress;
  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_in;
  logic [NUM_SPRITES-1:0]        load;
  logic [DATA_W-1:0]             rom_bits_out;
  logic [ADDR_W-1:0]             rom_addr;
  logic [DATA_W-1:0]             rom_bits;

  modport master (
    input  in_progress, rom_addr_in, rom_bits,
    output load, rom_bits_out, rom_addr
  );

  modport slave (
    output in_progress, rom_addr_in, rom_bits,
    input  load, rom_bits_out, rom_addr
  );
endinterface

// File: rtl/sprite_scheduler.sv
// Time-shares one sprite bitmap ROM between renderer slots during horizontal blank.
// Optional macro SPRITE_SCHED_ROTATE_EN: each scan starts after the last slot granted previously.
module sprite_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int LINE_BUDGET = NUM_SPRITES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               clr_overrun,
  sprite_scheduler_if.master bus,
  output logic               busy,
  output logic               scan_done,
  output logic               budget_hit,
  output logic               overrun
);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CNT_W = $clog2(NUM_SPRITES + 1);
  localparam int CYC_W = $clog2(SLOT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] ALL_SLOTS = CNT_W'(NUM_SPRITES);
  localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(LINE_BUDGET);
  localparam logic [CYC_W-1:0] SLOT_LAST = CYC_W'(SLOT_CYCLES - 1);

  // SLOT holds all but the final cycle of an active slot; NEXT is the final
  // cycle of any slot, where the scan either advances or ends.
  typedef enum logic [1:0] {IDLE, SLOT, NEXT} state_t;

  state_t           state;
  logic             hsync_q;
  logic [IDX_W-1:0] slot;
  logic [IDX_W-1:0] start_slot;
  logic [CNT_W-1:0] visited;
  logic [CNT_W-1:0] granted;
  logic [CYC_W-1:0] cyc;
  logic             grant_valid;
`ifdef SPRITE_SCHED_ROTATE_EN
  logic [IDX_W-1:0] last_granted;
`endif

  logic             rise;
  logic             scan_end;
  logic             do_enter;
  logic [IDX_W-1:0] entry_idx;
  logic             entry_active;
  logic [CNT_W-1:0] granted_base;
  logic [CNT_W-1:0] visited_base;

  assign rise         = hsync & ~hsync_q;
  assign scan_end     = (state == NEXT) && ((visited == ALL_SLOTS) || (granted == BUDGET));
  assign do_enter     = ((state == IDLE) && rise) || ((state == NEXT) && !scan_end);
  assign entry_idx    = (state == IDLE) ? start_slot
                      : ((slot == LAST_IDX) ? '0 : slot + 1'b1);
  assign entry_active = bus.in_progress[entry_idx];
  assign granted_base = (state == IDLE) ? '0 : granted;
  assign visited_base = (state == IDLE) ? '0 : visited;

  assign bus.rom_addr     = grant_valid ? bus.rom_addr_in[int'(slot)*ADDR_W +: ADDR_W] : '0;
  assign bus.rom_bits_out = bus.rom_bits;

`ifndef SPRITE_SCHED_ROTATE_EN
  assign start_slot = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hsync_q     <= 1'b0;
      slot        <= '0;
      visited     <= '0;
      granted     <= '0;
      cyc         <= '0;
      grant_valid <= 1'b0;
      bus.load    <= '0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      budget_hit  <= 1'b0;
      overrun     <= 1'b0;
`ifdef SPRITE_SCHED_ROTATE_EN
      start_slot   <= '0;
      last_granted <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low with non-blocking assignments here and
      // are raised further down only on the cycle they apply; last NBA wins.
      hsync_q    <= hsync;
      scan_done  <= 1'b0;
      budget_hit <= 1'b0;
      bus.load   <= '0;

      if (rise && busy)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;

      if (do_enter) begin
        // in_progress is sampled only here, at slot entry
        state       <= entry_active ? SLOT : NEXT;
        slot        <= entry_idx;
        busy        <= 1'b1;
        visited     <= visited_base + 1'b1;
        cyc         <= CYC_W'(1);
        grant_valid <= entry_active;
        if (entry_active) begin
          bus.load <= NUM_SPRITES'(1) << entry_idx;
          granted  <= granted_base + 1'b1;
`ifdef SPRITE_SCHED_ROTATE_EN
          last_granted <= entry_idx;
`endif
        end else begin
          granted <= granted_base;
        end
      end else begin
        case (state)
          SLOT: begin
            cyc <= cyc + 1'b1;
            if (cyc == SLOT_LAST)
              state <= NEXT;
          end
          NEXT: begin
            if (scan_end) begin
              state       <= IDLE;
              busy        <= 1'b0;
              grant_valid <= 1'b0;
              scan_done   <= 1'b1;
              budget_hit  <= (visited != ALL_SLOTS);
`ifdef SPRITE_SCHED_ROTATE_EN
              if (granted != '0)
                start_slot <= (last_granted == LAST_IDX) ? '0 : last_granted + 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: a full-budget instance and a LINE_BUDGET=2 instance,
// checked cycle by cycle against a queue of predicted scan cycles.
`timescale 1ns/1ps
module tb_sprite_scheduler;
  localparam int NS = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SC = 4;

  typedef struct packed {
    logic [NS-1:0] load;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    logic          bh;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hsync_a = 1'b0, hsync_b = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic busy_a, done_a, bh_a, ovr_a;
  logic busy_b, done_b, bh_b, ovr_b;
  logic [NS-1:0]    ip = '0;
  logic [NS*AW-1:0] addrs = '0;
  logic [DW-1:0]    bits = '0;
  logic             sel = 1'b0;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int start_a = 0;
  int start_b = 0;

  sprite_scheduler_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sprite_scheduler_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.in_progress = ip;
  assign bus_a.rom_addr_in = addrs;
  assign bus_a.rom_bits    = bits;
  assign bus_b.in_progress = ip;
  assign bus_b.rom_addr_in = addrs;
  assign bus_b.rom_bits    = bits;

  sprite_scheduler #(.NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW), .SLOT_CYCLES(SC),
                     .LINE_BUDGET(NS)) dut_a (
    .clk(clk), .reset(reset), .hsync(hsync_a), .clr_overrun(clr_a), .bus(bus_a),
    .busy(busy_a), .scan_done(done_a), .budget_hit(bh_a), .overrun(ovr_a)
  );

  sprite_scheduler #(.NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW), .SLOT_CYCLES(SC),
                     .LINE_BUDGET(2)) dut_b (
    .clk(clk), .reset(reset), .hsync(hsync_b), .clr_overrun(clr_b), .bus(bus_b),
    .busy(busy_b), .scan_done(done_b), .budget_hit(bh_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  logic [NS-1:0] o_load;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_bits;
  logic          o_busy, o_done, o_bh, o_ovr;
  assign o_load = sel ? bus_b.load : bus_a.load;
  assign o_addr = sel ? bus_b.rom_addr : bus_a.rom_addr;
  assign o_bits = sel ? bus_b.rom_bits_out : bus_a.rom_bits_out;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_bh   = sel ? bh_b : bh_a;
  assign o_ovr  = sel ? ovr_b : ovr_a;

  task automatic set_hsync(input logic v);
    if (sel) hsync_b = v;
    else     hsync_a = v;
  endtask

  // Walks the slots the way the scan is described and queues one record per cycle,
  // from the first cycle after the sampling edge through two idle cycles after scan_done.
  task automatic predict(input logic [NS-1:0] ipv, input int budget, input int start,
                         output int nstart, output int ncyc);
    exp_t e [0:63];
    logic [NS-1:0] one;
    int t, g, last, s;
    logic bh;
    one = 1; t = 1; g = 0; last = -1; bh = 1'b0;
    for (int i = 0; i < 64; i++) e[i] = '0;
    for (int v = 0; v < NS; v++) begin
      s = (start + v) % NS;
      if (ipv[s]) begin
        for (int c = 0; c < SC; c++) begin
          e[t+c].busy = 1'b1;
          e[t+c].addr = addrs[s*AW +: AW];
        end
        e[t].load = one << s;
        t += SC;
        g++;
        last = s;
      end else begin
        e[t].busy = 1'b1;
        t++;
      end
      if (v == NS - 1) break;
      if (g == budget) begin
        bh = 1'b1;
        break;
      end
    end
    e[t].done = 1'b1;
    e[t].bh   = bh;
`ifdef SPRITE_SCHED_ROTATE_EN
    nstart = (last >= 0) ? (last + 1) % NS : start;
`else
    nstart = 0;
`endif
    ncyc = t + 2;
    for (int i = 1; i <= ncyc; i++) sb.push_back(e[i]);
  endtask

  // Called at a negedge; hsync is raised so the next posedge is the sampling edge T.
  task automatic run_scan(input logic b, input logic [NS-1:0] ipv, input int rise2,
                          input string tag);
    int nstart, n;
    exp_t e;
    sel = b;
    ip  = ipv;
    if (b) begin
      predict(ipv, 2, start_b, nstart, n);
      start_b = nstart;
    end else begin
      predict(ipv, NS, start_a, nstart, n);
      start_a = nstart;
    end
    set_hsync(1'b1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL %s cyc%0d scoreboard empty", tag, k);
        break;
      end
      e = sb.pop_front();
      checks++;
      if (o_load !== e.load) begin
        errors++; $display("FAIL %s cyc%0d load got=%b exp=%b", tag, k, o_load, e.load);
      end
      checks++;
      if (o_addr !== e.addr) begin
        errors++; $display("FAIL %s cyc%0d rom_addr got=%h exp=%h", tag, k, o_addr, e.addr);
      end
      checks++;
      if (o_busy !== e.busy) begin
        errors++; $display("FAIL %s cyc%0d busy got=%b exp=%b", tag, k, o_busy, e.busy);
      end
      checks++;
      if (o_done !== e.done) begin
        errors++; $display("FAIL %s cyc%0d scan_done got=%b exp=%b", tag, k, o_done, e.done);
      end
      checks++;
      if (o_bh !== e.bh) begin
        errors++; $display("FAIL %s cyc%0d budget_hit got=%b exp=%b", tag, k, o_bh, e.bh);
      end
      checks++;
      if (o_bits !== bits) begin
        errors++; $display("FAIL %s cyc%0d rom_bits_out got=%h exp=%h", tag, k, o_bits, bits);
      end
      if (k == 1) set_hsync(1'b0);
      if (rise2 > 1 && k == rise2) set_hsync(1'b1);
      if (rise2 > 1 && k == rise2 + 1) set_hsync(1'b0);
    end
    checks++;
    if (o_ovr !== (rise2 > 1)) begin
      errors++; $display("FAIL %s overrun got=%b exp=%b", tag, o_ovr, (rise2 > 1));
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (bus_a.load !== '0 || bus_a.rom_addr !== '0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || bh_a !== 1'b0 || ovr_a !== 1'b0) begin
      errors++;
      $display("FAIL %s quiet got load=%b addr=%h busy=%b done=%b bh=%b ovr=%b exp all 0",
               tag, bus_a.load, bus_a.rom_addr, busy_a, done_a, bh_a, ovr_a);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset_hold");
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_quiet("after_release");
    end
  endtask

  task automatic test_full_scan;
    addrs = '0;
    addrs[2*AW +: AW] = 4'h7;
    bits = 8'hA5;
    run_scan(1'b0, 4'b1111, 0, "full");
  endtask

  task automatic test_sparse;
    addrs = 16'h4321;
    bits = 8'h3C;
    run_scan(1'b0, 4'b1010, 0, "sparse");
  endtask

  task automatic test_overrun;
    addrs = 16'h9A5B;
    bits = 8'h5A;
    run_scan(1'b0, 4'b1111, 6, "overrun");
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    checks++;
    if (ovr_a !== 1'b0) begin
      errors++; $display("FAIL clr_overrun overrun got=%b exp=0", ovr_a);
    end
  endtask

  task automatic test_mid_reset;
    sel = 1'b0;
    ip = 4'b1111;
    hsync_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) hsync_a = 1'b0;
      if (k == 5) begin
        checks++;
        if (bus_a.load !== 4'b0010) begin
          errors++; $display("FAIL mid_reset load@5 got=%b exp=0010", bus_a.load);
        end
      end
    end
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL mid_reset busy_before got=%b exp=1", busy_a);
    end
    #2 reset = 1'b0;
    #1 check_quiet("mid_reset_same_cycle");
    @(negedge clk);
    reset = 1'b1;
    start_a = 0;
    start_b = 0;
    repeat (5) begin
      @(negedge clk);
      check_quiet("mid_reset_release");
    end
  endtask

  task automatic test_budget;
    addrs = 16'hDCBA;
    bits = 8'h81;
    run_scan(1'b1, 4'b1111, 0, "budget_scan1");
    run_scan(1'b1, 4'b1111, 0, "budget_scan2");
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      addrs = NS*AW'($urandom);
      bits = DW'($urandom);
      run_scan(1'b0, NS'($urandom_range(0, 15)), 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_overrun();
    test_mid_reset();
    test_budget();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end
endmodule
